// File: rtl/avalon_arb_pkg.sv
// Shared types for the two-port Avalon-MM arbiter: FSM states, owner encoding, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package avalon_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Bit positions of the two requesters in the req/grant vectors.
  localparam int REQ_INST = 0;
  localparam int REQ_DATA = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // A one-hot grant vector names exactly one owner; an empty grant maps to INST
  // but callers only use this when a grant is present.
  function automatic owner_t grant_to_owner(input logic [1:0] grant);
    return grant[REQ_DATA] ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant picker: one-hot grant from {data, inst} requests; ties go to the port not granted last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples the grant only when it can accept a new owner.
// With AVALON_ARB_FIXED_PRIO_EN defined, DATA always wins a tie and 'last' is ignored.
module rr_arb2
  import avalon_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] grant
);

`ifdef AVALON_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // Pick one requester; a lone request is always granted.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
`ifdef AVALON_ARB_FIXED_PRIO_EN
        grant = 2'b10;
`else
        grant = (last == OWN_DATA) ? 2'b01 : 2'b10;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/avalon_mm_arbiter2.sv
// Merges an instruction (read-only) and a data Avalon-MM slave port onto one master port, one transaction in flight.
// Latency: request seen in cycle N, master command in N+1, slave acceptance in N+1 when m_waitrequest=0; read data combinational.
// Backpressure: both slave waitrequests stay high except the owner's in the cycle the master accepts; m_waitrequest holds the command.
// Build option AVALON_ARB_FIXED_PRIO_EN: DATA wins every tie and no last-grant state is kept.
module avalon_mm_arbiter2
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  // instruction slave port
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  // data slave port
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  // master port toward cache/SDRAM
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic                m_readdatavalid,
  input  logic [DATA_W-1:0]   m_readdata
);

  localparam int BE_W = DATA_W / 8;

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  owner_t            last_grant;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_read;
  logic              cmd_write;
  logic [BE_W-1:0]   cmd_be;
  logic [DATA_W-1:0] cmd_wdata;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              grant_any;
  logic              take_grant;
  logic              accept;
  logic              rd_done;

  // A data-port cycle with both read and write raised counts as one request.
  assign req        = {d_read | d_write, i_read};
  assign grant_any  = |grant;
  assign take_grant = (state == IDLE) && grant_any;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_grant),
    .grant (grant)
  );

`ifdef AVALON_ARB_FIXED_PRIO_EN
  assign last_grant = OWN_DATA;
`else
  // Remember who won the most recent grant so the next tie goes the other way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= OWN_DATA;
    end else if (take_grant) begin
      last_grant <= grant_to_owner(grant);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: grant in IDLE, hold in ISSUE until accepted, wait for the single read beat.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          accept    = 1'b1;
          state_nxt = cmd_write ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (m_readdatavalid) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's command when a grant is taken; it drives the master port unchanged until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= OWN_INST;
      cmd_addr  <= '0;
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
      cmd_be    <= '0;
      cmd_wdata <= '0;
    end else if (take_grant) begin
      owner <= grant_to_owner(grant);
      if (grant[REQ_DATA]) begin
        cmd_addr  <= d_address;
        cmd_read  <= ~d_write;
        cmd_write <= d_write;
        cmd_be    <= d_byteenable;
        cmd_wdata <= d_writedata;
      end else begin
        cmd_addr  <= i_address;
        cmd_read  <= 1'b1;
        cmd_write <= 1'b0;
        cmd_be    <= '1;
        cmd_wdata <= '0;
      end
    end
  end

  assign m_address    = cmd_addr;
  assign m_byteenable = cmd_be;
  assign m_writedata  = cmd_wdata;

  // Master strobes and slave handshakes; read data is routed to the owner without a register stage.
  always_comb begin
    m_read          = 1'b0;
    m_write         = 1'b0;
    i_waitrequest   = 1'b1;
    d_waitrequest   = 1'b1;
    i_readdatavalid = 1'b0;
    d_readdatavalid = 1'b0;
    i_readdata      = '0;
    d_readdata      = '0;

    if (state == ISSUE) begin
      m_read  = cmd_read;
      m_write = cmd_write;
    end

    if (accept) begin
      if (owner == OWN_INST) begin
        i_waitrequest = 1'b0;
      end else begin
        d_waitrequest = 1'b0;
      end
    end

    if (owner == OWN_INST) begin
      i_readdata      = m_readdata;
      i_readdatavalid = rd_done;
    end else begin
      d_readdata      = m_readdata;
      d_readdatavalid = rd_done;
    end
  end

endmodule

// File: tb/tb_avalon_mm_arbiter2.sv
// Self-checking bench for avalon_mm_arbiter2: directed scenarios plus randomized two-master traffic against a byte memory model.
// Latency: n/a.
// Backpressure: the bench-side memory slave inserts fixed or random waitrequest and read latency.
module tb_avalon_mm_arbiter2;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int TMO    = 200;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;
  logic              i_readdatavalid;
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [BE_W-1:0]   d_byteenable;
  logic [DATA_W-1:0] d_writedata;
  logic              d_waitrequest;
  logic [DATA_W-1:0] d_readdata;
  logic              d_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [BE_W-1:0]   m_byteenable;
  logic [DATA_W-1:0] m_writedata;
  logic              m_waitrequest;
  logic              m_readdatavalid;
  logic [DATA_W-1:0] m_readdata;

  always #5 clk = ~clk;

  avalon_mm_arbiter2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_byteenable(d_byteenable), .d_writedata(d_writedata),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // mem: contents of the memory behind the master port. ref_mem: what the slaves expect memory to hold.
  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];

  // Memory slave knobs: negative means randomize per transaction.
  int cfg_wait = 0;
  int cfg_lat  = 1;

  int i_vld_cnt = 0;
  int d_vld_cnt = 0;
  int inst_reads = 0;
  int data_reads = 0;
  logic log_en = 1'b0;
  logic [31:0] acc_log[$];

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]) * 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = idx(a);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] w);
    int b;
    b = idx(a);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) ref_mem[b+k] = w[8*k +: 8];
    end
  endfunction

  // Memory slave behind the master port: waitrequest stretch, then write bytes or return a read after a latency.
  initial begin
    int wcnt, cur_wait, resp_cnt, b;
    logic busy;
    logic [31:0] resp_data;
    wcnt = 0; cur_wait = 0; resp_cnt = 0; busy = 1'b0; resp_data = '0;
    m_waitrequest   = 1'b1;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    forever begin
      @(negedge clk);
      m_readdatavalid = 1'b0;
      m_readdata      = $urandom;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata      = resp_data;
        end
      end
      if (m_read || m_write) begin
        if (!busy) begin
          busy     = 1'b1;
          wcnt     = 0;
          cur_wait = (cfg_wait >= 0) ? cfg_wait : int'($urandom_range(0, 3));
        end
        if (wcnt < cur_wait) begin
          m_waitrequest = 1'b1;
          wcnt++;
        end else begin
          m_waitrequest = 1'b0;
          busy = 1'b0;
          b = idx(m_address);
          if (m_write) begin
            for (int k = 0; k < 4; k++) begin
              if (m_byteenable[k]) mem[b+k] = m_writedata[8*k +: 8];
            end
          end else begin
            resp_data = {mem[b+3], mem[b+2], mem[b+1], mem[b]};
            resp_cnt  = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 4));
          end
        end
      end else begin
        m_waitrequest = 1'b1;
        busy = 1'b0;
      end
    end
  end

  // Count response pulses per port and log accepted master addresses.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (i_readdatavalid) i_vld_cnt++;
      if (d_readdatavalid) d_vld_cnt++;
      if (log_en && (m_read || m_write) && !m_waitrequest) acc_log.push_back(m_address);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic inst_read(input logic [31:0] addr);
    int t;
    logic [31:0] exp;
    @(negedge clk);
    i_read = 1'b1; i_address = addr;
    t = 0;
    forever begin
      #1;
      if (!i_waitrequest) break;
      t++;
      if (t > TMO) begin
        n_checks++; n_errors++;
        $display("FAIL inst_accept_timeout addr=%h waited=%0d limit=%0d", addr, t, TMO);
        i_read = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
    i_read = 1'b0;
    inst_reads++;
    t = 0;
    forever begin
      #1;
      if (i_readdatavalid) break;
      t++;
      if (t > TMO) begin
        n_checks++; n_errors++;
        $display("FAIL inst_valid_timeout addr=%h waited=%0d limit=%0d", addr, t, TMO);
        return;
      end
      @(negedge clk);
    end
    exp = ref_word(addr);
    n_checks++;
    if (i_readdata !== exp) begin
      n_errors++;
      $display("FAIL inst_rdata addr=%h got=%h exp=%h", addr, i_readdata, exp);
    end
  endtask

  task automatic data_read(input logic [31:0] addr);
    int t;
    logic [31:0] exp;
    @(negedge clk);
    d_read = 1'b1; d_write = 1'b0; d_address = addr;
    t = 0;
    forever begin
      #1;
      if (!d_waitrequest) break;
      t++;
      if (t > TMO) begin
        n_checks++; n_errors++;
        $display("FAIL data_rd_accept_timeout addr=%h waited=%0d limit=%0d", addr, t, TMO);
        d_read = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp = ref_word(addr);
    @(negedge clk);
    d_read = 1'b0;
    data_reads++;
    t = 0;
    forever begin
      #1;
      if (d_readdatavalid) break;
      t++;
      if (t > TMO) begin
        n_checks++; n_errors++;
        $display("FAIL data_valid_timeout addr=%h waited=%0d limit=%0d", addr, t, TMO);
        return;
      end
      @(negedge clk);
    end
    n_checks++;
    if (d_readdata !== exp) begin
      n_errors++;
      $display("FAIL data_rdata addr=%h got=%h exp=%h", addr, d_readdata, exp);
    end
  endtask

  // A write raised together with d_read must still behave as a plain write.
  task automatic data_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] w, input logic both);
    int t;
    @(negedge clk);
    d_write = 1'b1; d_read = both; d_address = addr; d_byteenable = be; d_writedata = w;
    t = 0;
    forever begin
      #1;
      if (!d_waitrequest) break;
      t++;
      if (t > TMO) begin
        n_checks++; n_errors++;
        $display("FAIL data_wr_accept_timeout addr=%h waited=%0d limit=%0d", addr, t, TMO);
        d_write = 1'b0; d_read = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ref_write(addr, be, w);
    @(negedge clk);
    d_write = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    obs = {m_read, m_write, i_waitrequest, d_waitrequest, i_readdatavalid, d_readdatavalid};
    n_checks++;
    if (obs !== 6'b001100) begin
      n_errors++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 6'b001100);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    obs = {m_read, m_write, i_waitrequest, d_waitrequest, i_readdatavalid, d_readdatavalid};
    n_checks++;
    if (obs !== 6'b001100) begin
      n_errors++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs, 6'b001100);
    end
  endtask

  task automatic test_inst_read();
    int ipulse, dpulse, vcyc;
    logic [31:0] vdata;
    cfg_wait = 0; cfg_lat = 2;
    {mem[259], mem[258], mem[257], mem[256]} = 32'hDEADBEEF;
    {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]} = 32'hDEADBEEF;
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h100;
    #1;
    n_checks++;
    if ({m_read, i_waitrequest} !== 2'b01) begin
      n_errors++;
      $display("FAIL inst_idle_cycle m_read/i_wait got=%b exp=%b", {m_read, i_waitrequest}, 2'b01);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({m_read, m_write, i_waitrequest, d_waitrequest} !== 4'b1001) begin
      n_errors++;
      $display("FAIL inst_issue_strobes got=%b exp=%b", {m_read, m_write, i_waitrequest, d_waitrequest}, 4'b1001);
    end
    n_checks++;
    if ({m_address, m_byteenable, m_writedata} !== {32'h100, 4'hF, 32'h0}) begin
      n_errors++;
      $display("FAIL inst_issue_fields addr=%h be=%h wd=%h exp addr=100 be=f wd=0", m_address, m_byteenable, m_writedata);
    end
    @(negedge clk);
    i_read = 1'b0;
    ipulse = 0; dpulse = 0; vcyc = -1; vdata = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (i_readdatavalid) begin
        ipulse++;
        vcyc  = c;
        vdata = i_readdata;
      end
      if (d_readdatavalid) dpulse++;
    end
    n_checks++;
    if (ipulse !== 1 || vcyc !== 1) begin
      n_errors++;
      $display("FAIL inst_valid_pulse count=%0d at=%0d exp count=1 at=1", ipulse, vcyc);
    end
    n_checks++;
    if (vdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL inst_rdata_directed got=%h exp=%h", vdata, 32'hDEADBEEF);
    end
    n_checks++;
    if (dpulse !== 0) begin
      n_errors++;
      $display("FAIL inst_no_data_valid got=%0d exp=0", dpulse);
    end
  endtask

  task automatic test_data_write();
    logic [4:0]  wr_hist, wq_low;
    int          fields_ok, iwq_low;
    logic [31:0] old_w, exp_w, got_w;
    cfg_wait = 3; cfg_lat = 1;
    old_w = {mem[67], mem[66], mem[65], mem[64]};
    exp_w = {old_w[31:24], 8'h34, old_w[15:8], 8'h78};
    @(negedge clk);
    d_write = 1'b1; d_read = 1'b0; d_address = 32'h40; d_byteenable = 4'b0101; d_writedata = 32'h12345678;
    wr_hist = '0; wq_low = '0; fields_ok = 0; iwq_low = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) d_write = 1'b0;
      #1;
      wr_hist[c] = m_write;
      wq_low[c]  = ~d_waitrequest;
      if (!i_waitrequest) iwq_low++;
      if (c < 4 && m_address === 32'h40 && m_byteenable === 4'b0101 &&
          m_writedata === 32'h12345678 && m_read === 1'b0) fields_ok++;
    end
    ref_write(32'h40, 4'b0101, 32'h12345678);
    n_checks++;
    if (wr_hist !== 5'b01111) begin
      n_errors++;
      $display("FAIL write_hold m_write history got=%b exp=%b", wr_hist, 5'b01111);
    end
    n_checks++;
    if (wq_low !== 5'b01000) begin
      n_errors++;
      $display("FAIL write_waitreq d_waitrequest-low history got=%b exp=%b", wq_low, 5'b01000);
    end
    n_checks++;
    if (fields_ok !== 4 || iwq_low !== 0) begin
      n_errors++;
      $display("FAIL write_fields stable=%0d exp=4 inst_wait_low=%0d exp=0", fields_ok, iwq_low);
    end
    got_w = {mem[67], mem[66], mem[65], mem[64]};
    n_checks++;
    if (got_w !== exp_w) begin
      n_errors++;
      $display("FAIL write_bytes mem=%h exp=%h", got_w, exp_w);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_q[$];
    int last_g;
    // After reset the last grant is DATA.
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    cfg_wait = 0; cfg_lat = 1;
    acc_log.delete();
    last_g = 1;
    for (int r = 0; r < 2; r++) begin
`ifdef AVALON_ARB_FIXED_PRIO_EN
      exp_q.push_back(32'h20); exp_q.push_back(32'h10);
`else
      if (last_g == 1) begin
        exp_q.push_back(32'h10); exp_q.push_back(32'h20); last_g = 1;
      end else begin
        exp_q.push_back(32'h20); exp_q.push_back(32'h10); last_g = 0;
      end
`endif
    end
    log_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      fork
        inst_read(32'h10);
        data_read(32'h20);
      join
    end
    @(negedge clk);
    log_en = 1'b0;
    n_checks++;
    if (acc_log.size() !== 4) begin
      n_errors++;
      $display("FAIL rr_count accepted=%0d exp=4", acc_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (acc_log[k] !== exp_q[k]) begin
          n_errors++;
          $display("FAIL rr_order slot=%0d addr=%h exp=%h", k, acc_log[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    int bad, pulses;
    cfg_wait = 0; cfg_lat = 6;
    @(negedge clk);
    d_read = 1'b1; d_write = 1'b0; d_address = 32'h200;
    @(negedge clk);
    #1;
    n_checks++;
    if (d_waitrequest !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_accept d_waitrequest=%b exp=0", d_waitrequest);
    end
    @(negedge clk);
    d_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    obs = {m_read, m_write, i_waitrequest, d_waitrequest, i_readdatavalid, d_readdatavalid};
    n_checks++;
    if (obs !== 6'b001100) begin
      n_errors++;
      $display("FAIL midrst_in_reset got=%b exp=%b", obs, 6'b001100);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0; pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      obs = {m_read, m_write, i_waitrequest, d_waitrequest, i_readdatavalid, d_readdatavalid};
      if (obs !== 6'b001100) bad++;
      if (i_readdatavalid || d_readdatavalid) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || bad !== 0) begin
      n_errors++;
      $display("FAIL midrst_late_response valid_pulses=%0d nonidle_cycles=%0d exp 0 and 0", pulses, bad);
    end
  endtask

  task automatic test_random();
    int diff;
    cfg_wait = -1; cfg_lat = -1;
    @(negedge clk);
    i_vld_cnt = 0; d_vld_cnt = 0; inst_reads = 0; data_reads = 0;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          inst_read(32'($urandom_range(0, 127) * 4));
        end
      end
      begin
        for (int k = 0; k < 400; k++) begin
          int r;
          logic [31:0] a;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          r = int'($urandom_range(0, 2));
          a = 32'(512 + $urandom_range(0, 127) * 4);
          if (r == 0) data_read(a);
          else data_write(a, 4'($urandom), $urandom, r == 2);
        end
      end
    join
    repeat (10) @(negedge clk);
    n_checks++;
    if (i_vld_cnt !== inst_reads) begin
      n_errors++;
      $display("FAIL rand_inst_responses pulses=%0d reads=%0d", i_vld_cnt, inst_reads);
    end
    n_checks++;
    if (d_vld_cnt !== data_reads) begin
      n_errors++;
      $display("FAIL rand_data_responses pulses=%0d reads=%0d", d_vld_cnt, data_reads);
    end
    diff = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) diff++;
    end
    n_checks++;
    if (diff !== 0) begin
      n_errors++;
      $display("FAIL rand_memory_image differing_bytes=%0d exp=0", diff);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_byteenable = '0; d_writedata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_inst_read();
    test_data_write();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
